// File: rtl/cve2_xif_result_queue_pkg.sv
// Shared types for the XIF result queue: per-entry flags, derived entry state and default sizes.
package cve2_xif_result_queue_pkg;

  localparam int unsigned RQ_DEPTH          = 4;
  localparam int unsigned RQ_X_ID_WIDTH     = 4;
  localparam int unsigned RQ_X_HARTID_WIDTH = 1;
  localparam int unsigned RQ_X_RFW_WIDTH    = 32;
  localparam int unsigned RQ_X_DUALWRITE    = 0;

  typedef struct packed {
    logic live;
    logic committed;
    logic killed;
    logic done;
  } rq_flags_t;

  typedef enum logic [2:0] {
    RQ_EMPTY,
    RQ_ISSUED,
    RQ_DONE,
    RQ_COMMITTED,
    RQ_READY,
    RQ_KILLED
  } rq_state_e;

  // Killed dominates: a killed entry never produces a result whatever else it collected.
  function automatic rq_state_e rq_state(input rq_flags_t f);
    if (!f.live)                return RQ_EMPTY;
    if (f.killed)               return RQ_KILLED;
    if (f.committed && f.done)  return RQ_READY;
    if (f.committed)            return RQ_COMMITTED;
    if (f.done)                 return RQ_DONE;
    return RQ_ISSUED;
  endfunction

endpackage

// File: rtl/cve2_xif_result_queue_if.sv
// Alloc / commit / execution-unit / result channels of the XIF result queue.
interface cve2_xif_result_queue_if #(
  parameter int unsigned X_ID_WIDTH     = cve2_xif_result_queue_pkg::RQ_X_ID_WIDTH,
  parameter int unsigned X_HARTID_WIDTH = cve2_xif_result_queue_pkg::RQ_X_HARTID_WIDTH,
  parameter int unsigned X_RFW_WIDTH    = cve2_xif_result_queue_pkg::RQ_X_RFW_WIDTH,
  parameter int unsigned X_DUALWRITE    = cve2_xif_result_queue_pkg::RQ_X_DUALWRITE
) ();

  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [X_ID_WIDTH-1:0]     alloc_id;
  logic [X_HARTID_WIDTH-1:0] alloc_hartid;
  logic [X_DUALWRITE:0]      alloc_we;

  logic                      commit_valid;
  logic [X_ID_WIDTH-1:0]     commit_id;
  logic                      commit_kill;

  logic                      exu_valid;
  logic                      exu_ready;
  logic [X_ID_WIDTH-1:0]     exu_id;
  logic [X_RFW_WIDTH-1:0]    exu_data;
  logic [4:0]                exu_rd;
  logic                      exu_exc;
  logic [5:0]                exu_exccode;

  logic                      result_valid;
  logic                      result_ready;
  logic [X_ID_WIDTH-1:0]     result_id;
  logic [X_HARTID_WIDTH-1:0] result_hartid;
  logic [X_RFW_WIDTH-1:0]    result_data;
  logic [4:0]                result_rd;
  logic [X_DUALWRITE:0]      result_we;
  logic                      result_exc;
  logic [5:0]                result_exccode;

  modport master (
    output alloc_valid, alloc_id, alloc_hartid, alloc_we,
    input  alloc_ready,
    output commit_valid, commit_id, commit_kill,
    output exu_valid, exu_id, exu_data, exu_rd, exu_exc, exu_exccode,
    input  exu_ready,
    input  result_valid, result_id, result_hartid, result_data, result_rd,
           result_we, result_exc, result_exccode,
    output result_ready
  );

  modport slave (
    input  alloc_valid, alloc_id, alloc_hartid, alloc_we,
    output alloc_ready,
    input  commit_valid, commit_id, commit_kill,
    input  exu_valid, exu_id, exu_data, exu_rd, exu_exc, exu_exccode,
    output exu_ready,
    output result_valid, result_id, result_hartid, result_data, result_rd,
           result_we, result_exc, result_exccode,
    input  result_ready
  );

endinterface

// File: rtl/cve2_xif_result_queue.sv
// In-order XIF result queue: tracks offloads, collects out-of-order results, emits them in issue order.
// Optional CVE2_XIF_RQ_PERF_EN adds saturating counters of emitted results and dropped killed entries.
module cve2_xif_result_queue
  import cve2_xif_result_queue_pkg::*;
#(
  parameter int unsigned DEPTH          = RQ_DEPTH,
  parameter int unsigned X_ID_WIDTH     = RQ_X_ID_WIDTH,
  parameter int unsigned X_HARTID_WIDTH = RQ_X_HARTID_WIDTH,
  parameter int unsigned X_RFW_WIDTH    = RQ_X_RFW_WIDTH,
  parameter int unsigned X_DUALWRITE    = RQ_X_DUALWRITE
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  cve2_xif_result_queue_if.slave xif,
  output logic                   empty_o
`ifdef CVE2_XIF_RQ_PERF_EN
  ,
  output logic [31:0]            perf_results_o,
  output logic [31:0]            perf_killed_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned WE_W  = X_DUALWRITE + 1;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]     id;
    logic [X_HARTID_WIDTH-1:0] hartid;
    logic [WE_W-1:0]           we;
    logic [X_RFW_WIDTH-1:0]    data;
    logic [4:0]                rd;
    logic                      exc;
    logic [5:0]                exccode;
  } rq_entry_t;

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_idx, rd_idx;
  rq_flags_t        flags_q [DEPTH];
  rq_flags_t        flags_d [DEPTH];
  rq_entry_t        entry_q [DEPTH];
  rq_entry_t        head_entry;
  rq_state_e        head_state;

  logic             full, alloc_fire, pop, head_ready, head_killed, commit_new;
  logic [DEPTH-1:0] commit_hit, exu_hit;

  assign wr_idx = wr_ptr_q[PTR_W-1:0];
  assign rd_idx = rd_ptr_q[PTR_W-1:0];
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

  // Ready comes from registered pointers only, so a pop never frees space for the same cycle.
  assign xif.alloc_ready = !full;
  assign xif.exu_ready   = 1'b1;
  assign empty_o         = (wr_ptr_q == rd_ptr_q);
  assign alloc_fire      = xif.alloc_valid && !full;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cam
    assign commit_hit[i] = xif.commit_valid && flags_q[i].live && !flags_q[i].committed &&
                           !flags_q[i].killed && (entry_q[i].id == xif.commit_id);
    assign exu_hit[i]    = xif.exu_valid && flags_q[i].live && !flags_q[i].done &&
                           !flags_q[i].killed && (entry_q[i].id == xif.exu_id);
  end

  // A commit for the ID being allocated this cycle lands on the new entry.
  assign commit_new = xif.commit_valid && alloc_fire && (xif.commit_id == xif.alloc_id);

  assign head_entry  = entry_q[rd_idx];
  assign head_state  = rq_state(flags_q[rd_idx]);
  assign head_ready  = (head_state == RQ_READY);
  assign head_killed = (head_state == RQ_KILLED);
  assign pop         = (head_ready && xif.result_ready) || head_killed;

  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(alloc_fire);
    rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      flags_d[i] = flags_q[i];
      if (commit_hit[i]) begin
        if (xif.commit_kill) flags_d[i].killed    = 1'b1;
        else                 flags_d[i].committed = 1'b1;
      end
      if (exu_hit[i]) flags_d[i].done = 1'b1;
      if (pop && (rd_idx == PTR_W'(i))) flags_d[i] = '0;
      if (alloc_fire && (wr_idx == PTR_W'(i))) begin
        flags_d[i].live      = 1'b1;
        flags_d[i].committed = commit_new && !xif.commit_kill;
        flags_d[i].killed    = commit_new && xif.commit_kill;
        flags_d[i].done      = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) flags_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) flags_q[i] <= flags_d[i];
    end
  end

  // NOTE: payload storage has no reset; the live flag qualifies it and outputs are masked when idle.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_fire && (wr_idx == PTR_W'(i))) begin
        entry_q[i].id     <= xif.alloc_id;
        entry_q[i].hartid <= xif.alloc_hartid;
        entry_q[i].we     <= xif.alloc_we;
      end
      if (exu_hit[i]) begin
        entry_q[i].data    <= xif.exu_data;
        entry_q[i].rd      <= xif.exu_rd;
        entry_q[i].exc     <= xif.exu_exc;
        entry_q[i].exccode <= xif.exu_exccode;
      end
    end
  end

  assign xif.result_valid   = head_ready;
  assign xif.result_id      = head_ready ? head_entry.id      : '0;
  assign xif.result_hartid  = head_ready ? head_entry.hartid  : '0;
  assign xif.result_data    = head_ready ? head_entry.data    : '0;
  assign xif.result_rd      = head_ready ? head_entry.rd      : '0;
  assign xif.result_exc     = head_ready ? head_entry.exc     : 1'b0;
  assign xif.result_exccode = head_ready ? head_entry.exccode : '0;
  assign xif.result_we      = head_ready ? (head_entry.we & {WE_W{~head_entry.exc}}) : '0;

`ifdef CVE2_XIF_RQ_PERF_EN
  logic [31:0] perf_results_q, perf_killed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_results_q <= '0;
      perf_killed_q  <= '0;
    end else begin
      if (head_ready && xif.result_ready && (perf_results_q != '1))
        perf_results_q <= perf_results_q + 32'd1;
      if (head_killed && (perf_killed_q != '1))
        perf_killed_q <= perf_killed_q + 32'd1;
    end
  end

  assign perf_results_o = perf_results_q;
  assign perf_killed_o  = perf_killed_q;
`endif

`ifndef SYNTHESIS
  logic [DEPTH-1:0] alloc_dup;

  for (genvar i = 0; i < DEPTH; i++) begin : g_dup
    assign alloc_dup[i] = flags_q[i].live && (entry_q[i].id == xif.alloc_id) &&
                          !(pop && (rd_idx == PTR_W'(i)));
  end

  a_result_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    xif.result_valid && !xif.result_ready |=> xif.result_valid);

  a_unique_live_id : assert property (@(posedge clk_i) disable iff (!rst_ni)
    alloc_fire |-> (alloc_dup == '0));

  a_commit_matches : assert property (@(posedge clk_i) disable iff (!rst_ni)
    xif.commit_valid |-> ((|commit_hit) || commit_new));
`endif

endmodule
